// File: rtl/fetch_align_unit_pkg.sv
// Shared types and helpers for the RV32IC fetch/align unit.
package fetch_align_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [15:0] halfword_t;

  // Fetch sequencer: idle for one cycle after reset, then free-running.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  // A halfword starts a 16-bit instruction unless its two LSBs are both set.
  function automatic logic is_rvc(halfword_t h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_unit_if.sv
// Fetch unit bus bundle: imem read port, execute redirect, decode output.
// master = fetch unit side, slave = memory/execute/decode side.
interface fetch_align_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        redir_valid;
  logic [31:0] redir_pc;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [31:0] instr_pc;
  logic        instr_is_c;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    input  redir_valid, redir_pc,
    output instr_valid, instr_o, instr_pc, instr_is_c,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    output redir_valid, redir_pc,
    input  instr_valid, instr_o, instr_pc, instr_is_c,
    output instr_ready
  );

endinterface

// File: rtl/fetch_align_unit_hw_fifo.sv
// Halfword FIFO with up to two pushes and two pops per cycle and a flush.
// Entries are kept head-aligned (index 0 = oldest) so the two head
// halfwords come straight from flops.
module hw_fifo
  import fetch_align_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 6,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [1:0]      push_n,
  input  halfword_t [1:0] push_hw,
  input  logic [1:0]      pop_n,
  output logic [CW-1:0]   count,
  output halfword_t [1:0] head
);

  halfword_t [DEPTH-1:0] mem_q, mem_d;
  logic [CW-1:0]         count_q, count_d;
  int unsigned           keep;

  // Next contents: shift out popped entries, append pushes behind survivors.
  always_comb begin
    keep    = 32'(count_q) - 32'(pop_n);
    mem_d   = mem_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q - CW'(pop_n) + CW'(push_n);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i < keep) begin
          if (i + 32'(pop_n) < DEPTH) mem_d[IW'(i)] = mem_q[IW'(i + 32'(pop_n))];
        end else if (i - keep < 32'(push_n)) begin
          mem_d[IW'(i)] = push_hw[1'(i - keep)];
        end
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  // Head view for the aligner.
  always_comb begin
    count   = count_q;
    head[0] = mem_q[0];
    head[1] = mem_q[1];
  end

endmodule

// File: rtl/fetch_align_unit.sv
// RV32IC instruction fetch: issues word reads, buffers halfwords, aligns
// 16/32-bit instructions for decode and handles execute-stage redirects.
module fetch_align_unit
  import fetch_align_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_HW    = 6,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic               clk,
  input  logic               rst,
  fetch_align_unit_if.master bus
);

  localparam int unsigned CW = $clog2(BUF_HW + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_addr_q;
  logic [XLEN-1:0] pc_q;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q;
  logic            skip_lo_q;

  logic [CW-1:0]   fifo_count;
  halfword_t [1:0] head;
  halfword_t [1:0] push_hw;
  logic [1:0]      push_n, pop_n;
  logic            head_c, avail, can_issue, req, accept, rsp, resp_keep, xfer;

  hw_fifo #(.DEPTH(BUF_HW)) u_hw_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.redir_valid),
    .push_n  (push_n),
    .push_hw (push_hw),
    .pop_n   (pop_n),
    .count   (fifo_count),
    .head    (head)
  );

  // Sequencer next state and issue permission (room for all in-flight words plus one).
  always_comb begin
    state_d   = state_q;
    can_issue = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  can_issue = (32'(outst_q) < MAX_OUTST) &&
                           (BUF_HW - 32'(fifo_count) >= 2 * (32'(outst_q) + 1));
      default: state_d = ST_IDLE;
    endcase
  end

  // Request, response filtering, alignment and FIFO push/pop control.
  always_comb begin
    head_c     = is_rvc(head[0]);
    avail      = head_c ? (fifo_count != '0) : (fifo_count >= CW'(2));
    req        = can_issue && !bus.redir_valid;
    accept     = req && bus.imem_ready;
    // Responses with nothing outstanding predate a reset and are ignored.
    rsp        = bus.imem_rvalid && (outst_q != '0);
    resp_keep  = rsp && (drop_q == '0) && !bus.redir_valid;
    xfer       = avail && bus.instr_ready && !bus.redir_valid;
    push_n     = 2'd0;
    push_hw[0] = bus.imem_rdata[15:0];
    push_hw[1] = bus.imem_rdata[31:16];
    if (resp_keep) begin
      if (skip_lo_q) begin
        push_n     = 2'd1;
        push_hw[0] = bus.imem_rdata[31:16];
      end else begin
        push_n = 2'd2;
      end
    end
    pop_n   = xfer ? (head_c ? 2'd1 : 2'd2) : 2'd0;
    outst_d = outst_q + OW'(accept) - OW'(rsp);
  end

  // PC, fetch address, outstanding/drop counters and redirect handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= RESET_PC & 32'hFFFF_FFFC;
      pc_q         <= RESET_PC;
      outst_q      <= '0;
      drop_q       <= '0;
      skip_lo_q    <= RESET_PC[1];
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      if (bus.redir_valid) begin
        fetch_addr_q <= bus.redir_pc & 32'hFFFF_FFFC;
        pc_q         <= bus.redir_pc & 32'hFFFF_FFFE;
        skip_lo_q    <= bus.redir_pc[1];
        drop_q       <= outst_d;
      end else begin
        if (accept) fetch_addr_q <= fetch_addr_q + 32'd4;
        if (xfer) pc_q <= pc_q + (head_c ? 32'd2 : 32'd4);
        if (rsp && (drop_q != '0)) drop_q <= drop_q - OW'(1);
        if (resp_keep) skip_lo_q <= 1'b0;
      end
    end
  end

  // Output drive: instruction view of the FIFO head plus registered PC.
  always_comb begin
    bus.imem_req    = req;
    bus.imem_addr   = fetch_addr_q;
    bus.instr_valid = avail;
    bus.instr_is_c  = avail && head_c;
    bus.instr_pc    = pc_q;
    bus.instr_o     = '0;
    if (avail) bus.instr_o = head_c ? {16'h0000, head[0]} : {head[1], head[0]};
  end

endmodule
